// File: rtl/nmea_pkg.sv
// rtl/nmea_pkg.sv - shared states, error codes, characters and hex helpers for NMEA parsing
package nmea_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFIX,
      S_FIELD,
      S_SUM_HI,
      S_SUM_LO,
      S_DONE
   } state_t;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_CHECKSUM  = 3'd1;
   localparam logic [2:0] ERR_FIELD_LEN = 3'd2;
   localparam logic [2:0] ERR_TOO_MANY  = 3'd3;
   localparam logic [2:0] ERR_HEX       = 3'd4;
   localparam logic [2:0] ERR_RESTART   = 3'd5;
   localparam logic [2:0] ERR_TIMEOUT   = 3'd6;

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_STAR   = 8'h2A;

   // Checksum digits may be upper or lower case.
   function automatic logic is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) ||
             (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

   // Letters share the low nibble 1..6 in both cases, so adding 9 gives 10..15.
   function automatic logic [3:0] hex_value(input logic [7:0] c);
      return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
   endfunction

endpackage

// File: rtl/nmea_field_buffer.sv
// rtl/nmea_field_buffer.sv - shift-in character buffer with length counter for one field
module nmea_field_buffer
#(
   parameter int  B       = 8,
   parameter int  MAX_LEN = 10,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 push,
   input  logic [B-1:0]         push_data,
   output logic [MAX_LEN*B-1:0] data,
   output logic [LEN_W-1:0]     len,
   output logic                 overflow
);

   // Buffer is full: a further push would overflow, so it is dropped and the caller decides.
   assign overflow = (len == LEN_W'(MAX_LEN));

   // Newest character enters the low byte so the field text stays right-aligned.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data <= '0;
         len  <= '0;
      end else if (clear) begin
         data <= '0;
         len  <= '0;
      end else if (push && !overflow) begin
         data <= (data << B) | (MAX_LEN*B)'(push_data);
         len  <= len + LEN_W'(1);
      end
   end

endmodule

// File: rtl/nmea_sentence_parser.sv
// rtl/nmea_sentence_parser.sv - NMEA-0183 prefix match, field split and checksum check
module nmea_sentence_parser
   import nmea_pkg::*;
#(
   parameter int                    B             = 8,
   parameter int                    PREFIX_LEN    = 5,
   parameter logic [PREFIX_LEN*B-1:0] PREFIX      = "GPZDA",
   parameter int                    MAX_FIELDS    = 8,
   parameter int                    MAX_FIELD_LEN = 10,
   parameter int                    TIMEOUT       = 100000,
   localparam int IDX_W = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1,
   localparam int LEN_W = $clog2(MAX_FIELD_LEN + 1),
   localparam int CNT_W = $clog2(MAX_FIELDS + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       load,
   input  logic [B-1:0]               data,
   output logic                       field_valid,
   output logic [IDX_W-1:0]           field_index,
   output logic [LEN_W-1:0]           field_len,
   output logic [MAX_FIELD_LEN*B-1:0] field_data,
   output logic                       sentence_done,
   output logic                       sentence_ok,
   output logic [CNT_W-1:0]           field_count,
   output logic [2:0]                 error_code
);

   localparam int POS_W = $clog2(PREFIX_LEN + 1);
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t                     state, state_n;
   logic [7:0]                 acc, acc_n;
   logic [POS_W-1:0]           pos, pos_n;
   logic [CNT_W-1:0]           field_idx, idx_n;
   logic [3:0]                 sum_hi, hi_n;
   logic [TMO_W-1:0]           idle_cnt, idle_n;
   logic                       fv_n, done_n, ok_n;
   logic [IDX_W-1:0]           findex_n;
   logic [LEN_W-1:0]           flen_n;
   logic [MAX_FIELD_LEN*B-1:0] fdata_n;
   logic [CNT_W-1:0]           count_n;
   logic [2:0]                 err_n, code;
   logic                       start, finish, active, timed_out;
   logic [B-1:0]               prefix_char;
   logic                       buf_clear, buf_push, buf_overflow;
   logic [MAX_FIELD_LEN*B-1:0] buf_data;
   logic [LEN_W-1:0]           buf_len;

   nmea_field_buffer #(.B(B), .MAX_LEN(MAX_FIELD_LEN)) u_field_buffer (
      .clock     (clock),
      .reset     (reset),
      .clear     (buf_clear),
      .push      (buf_push),
      .push_data (data),
      .data      (buf_data),
      .len       (buf_len),
      .overflow  (buf_overflow)
   );

   assign active    = (state == S_PREFIX) || (state == S_FIELD) ||
                      (state == S_SUM_HI) || (state == S_SUM_LO);
   assign timed_out = (TIMEOUT != 0) && active && !load &&
                      (idle_cnt == TMO_W'(TIMEOUT - 1));

   // Expected identifier character for the current prefix position, first character first.
   always_comb begin
      prefix_char = '0;
      for (int i = 0; i < PREFIX_LEN; i++) begin
         if (pos == POS_W'(i)) prefix_char = PREFIX[(PREFIX_LEN-1-i)*B +: B];
      end
   end

   // Next-state, datapath and registered-output values for the sentence FSM.
   always_comb begin
      state_n   = state;
      acc_n     = acc;
      pos_n     = pos;
      idx_n     = field_idx;
      hi_n      = sum_hi;
      idle_n    = (load || !active || TIMEOUT == 0) ? '0 : idle_cnt + TMO_W'(1);
      buf_clear = 1'b0;
      buf_push  = 1'b0;
      fv_n      = 1'b0;
      findex_n  = field_index;
      flen_n    = field_len;
      fdata_n   = field_data;
      done_n    = 1'b0;
      ok_n      = sentence_ok;
      count_n   = field_count;
      err_n     = error_code;
      start     = 1'b0;
      finish    = 1'b0;
      code      = ERR_NONE;

      case (state)
         S_IDLE, S_DONE: begin
            state_n = S_IDLE;
            start   = load && (data == CH_DOLLAR);
         end
         S_PREFIX: begin
            if (load) begin
               if (data == CH_DOLLAR) begin
                  finish = 1'b1;
                  code   = ERR_RESTART;
                  start  = 1'b1;
               end else if (pos < POS_W'(PREFIX_LEN) && data == prefix_char) begin
                  pos_n = pos + POS_W'(1);
                  acc_n = acc ^ data;
               end else if (pos == POS_W'(PREFIX_LEN) && data == CH_COMMA) begin
                  state_n = S_FIELD;
                  acc_n   = acc ^ data;
               end else begin
                  state_n = S_IDLE;
               end
            end else if (timed_out) begin
               state_n = S_IDLE;
            end
         end
         S_FIELD: begin
            if (load) begin
               if (data == CH_DOLLAR) begin
                  finish = 1'b1;
                  code   = ERR_RESTART;
                  start  = 1'b1;
               end else if (data == CH_COMMA || data == CH_STAR) begin
                  if (field_idx == CNT_W'(MAX_FIELDS)) begin
                     finish = 1'b1;
                     code   = ERR_TOO_MANY;
                  end else begin
                     fv_n      = 1'b1;
                     findex_n  = field_idx[IDX_W-1:0];
                     flen_n    = buf_len;
                     fdata_n   = buf_data;
                     buf_clear = 1'b1;
                     idx_n     = field_idx + CNT_W'(1);
                     if (data == CH_STAR) state_n = S_SUM_HI;
                     else                 acc_n   = acc ^ data;
                  end
               end else if (buf_overflow) begin
                  finish = 1'b1;
                  code   = ERR_FIELD_LEN;
               end else begin
                  buf_push = 1'b1;
                  acc_n    = acc ^ data;
               end
            end else if (timed_out) begin
               finish = 1'b1;
               code   = ERR_TIMEOUT;
            end
         end
         S_SUM_HI, S_SUM_LO: begin
            if (load) begin
               if (data == CH_DOLLAR) begin
                  finish = 1'b1;
                  code   = ERR_RESTART;
                  start  = 1'b1;
               end else if (!is_hex(data)) begin
                  finish = 1'b1;
                  code   = ERR_HEX;
               end else if (state == S_SUM_HI) begin
                  hi_n    = hex_value(data);
                  state_n = S_SUM_LO;
               end else begin
                  finish = 1'b1;
                  code   = ({sum_hi, hex_value(data)} == acc) ? ERR_NONE : ERR_CHECKSUM;
               end
            end else if (timed_out) begin
               finish = 1'b1;
               code   = ERR_TIMEOUT;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // A restarting "$" reports the old sentence and opens the new one in the same cycle.
      if (finish) begin
         done_n  = 1'b1;
         ok_n    = (code == ERR_NONE);
         count_n = field_idx;
         err_n   = code;
         state_n = S_DONE;
      end
      if (start) begin
         state_n   = S_PREFIX;
         acc_n     = '0;
         pos_n     = '0;
         idx_n     = '0;
         hi_n      = '0;
         idle_n    = '0;
         buf_clear = 1'b1;
      end
   end

   // State register and registered outputs; reset drops any sentence in progress silently.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         acc           <= '0;
         pos           <= '0;
         field_idx     <= '0;
         sum_hi        <= '0;
         idle_cnt      <= '0;
         field_valid   <= 1'b0;
         field_index   <= '0;
         field_len     <= '0;
         field_data    <= '0;
         sentence_done <= 1'b0;
         sentence_ok   <= 1'b0;
         field_count   <= '0;
         error_code    <= ERR_NONE;
      end else begin
         state         <= state_n;
         acc           <= acc_n;
         pos           <= pos_n;
         field_idx     <= idx_n;
         sum_hi        <= hi_n;
         idle_cnt      <= idle_n;
         field_valid   <= fv_n;
         field_index   <= findex_n;
         field_len     <= flen_n;
         field_data    <= fdata_n;
         sentence_done <= done_n;
         sentence_ok   <= ok_n;
         field_count   <= count_n;
         error_code    <= err_n;
      end
   end

endmodule

// File: doc/nmea_sentence_parser.md
Name: nmea_sentence_parser

Overview:
Generic NMEA-0183 sentence parser. It is the parametrised successor to the fixed-layout GPZDA receiver.
- Matches a configurable "$<talker><sentence>," prefix.
- Splits the remaining variable-length comma-separated fields and emits each one as a one-cycle strobe.
- Verifies the "*hh" checksum and reports a typed error code.
- Sits between the UART byte receiver and sentence-specific decoders (ZDA, RMC, GGA), so each decoder only converts field contents.

Parameters:
B, 8, bits per character
PREFIX_LEN, 5, prefix length in characters, excluding "$" and ","
PREFIX, "GPZDA", expected talker+sentence identifier, PREFIX_LEN*B bits
MAX_FIELDS, 8, maximum fields after the prefix, must be ≥1
MAX_FIELD_LEN, 10, maximum characters per field, must be ≥1
TIMEOUT, 100000, maximum idle clocks between bytes inside a sentence; 0 disables the timeout

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
load  in  1  data is valid this cycle
data  in  B  received character
field_valid  out  1  one-cycle strobe: field_* hold a completed field
field_index  out  clog2(MAX_FIELDS)  0-based field number after the prefix
field_len  out  clog2(MAX_FIELD_LEN+1)  number of characters in the field, 0 allowed
field_data  out  MAX_FIELD_LEN*B  field text, right-aligned (last character in bits [B-1:0]), unused upper bytes zero
sentence_done  out  1  one-cycle strobe at the end of a sentence, success or error
sentence_ok  out  1  valid with sentence_done: checksum good and no error
field_count  out  clog2(MAX_FIELDS+1)  fields emitted in this sentence, valid with sentence_done
error_code  out  3  valid with sentence_done: 0 none, 1 checksum mismatch, 2 field too long, 3 too many fields, 4 non-hex checksum character, 5 unexpected "$" (restart), 6 timeout

Behaviour:
- Reset: all outputs 0, state S_IDLE, checksum accumulator 0, counters 0.
- Bytes are consumed only on cycles where load=1. All outputs are registered. Strobes rise the cycle after the triggering byte is loaded and last exactly 1 cycle.
- States: S_IDLE, S_PREFIX, S_FIELD, S_SUM_HI, S_SUM_LO, S_DONE.
- S_IDLE: "$" → S_PREFIX, clear the accumulator and counters. Any other byte, including CR and LF, is ignored.
- S_PREFIX: compare against PREFIX then ",", one character per load.
  - Any mismatch → S_IDLE silently, with no sentence_done. Foreign sentences are not errors.
  - Full match → S_FIELD.
- Checksum accumulator: XOR of every byte strictly between "$" and "*", including the prefix and commas.
- S_FIELD:
  - A non-delimiter byte shifts into the field buffer (old content shifts up by B) and increments the length.
  - "," or "*" emits the field: field_valid=1, field_index = current index, field_len, field_data; then clear the buffer and increment the index.
  - "*" additionally moves to S_SUM_HI.
  - An empty field ",," emits field_len=0 and field_data=0.
- S_SUM_HI / S_SUM_LO: accept 0-9, A-F, a-f. The two nibbles form the received checksum.
  - After S_SUM_LO → S_DONE, with error_code=1 if the received checksum ≠ the accumulator.
- S_DONE: lasts 1 cycle; drives sentence_done and then returns to S_IDLE. A load during S_DONE is processed as in S_IDLE, so "$" is accepted.
- Errors (each → S_DONE with the code shown; no further field_valid for that sentence):
  - MAX_FIELD_LEN+1-th character in a field: 2.
  - Delimiter that would emit field number MAX_FIELDS+1: 3.
  - Non-hex character in S_SUM_*: 4.
- "$" in any state other than S_IDLE/S_DONE: sentence_done with error_code=5, and the "$" simultaneously starts a new sentence (next state S_PREFIX, accumulator reset). It is not dropped.
- Timeout: an idle counter counts clocks with load=0 in S_PREFIX, S_FIELD and S_SUM_*. At TIMEOUT it gives error_code=6 → S_DONE (or S_IDLE if the state was S_PREFIX, silently). A load clears the counter.
- field_count = number of field_valid strobes issued for this sentence.
- Consumers discard buffered fields unless sentence_ok.
- The block has no back-pressure; consumers capture on field_valid.
- Reset mid-sentence: immediate return to S_IDLE with outputs cleared; no sentence_done.

Decomposition:
- Shared package nmea_pkg holds:
  - the state enum;
  - the error_code localparams (ERR_NONE…ERR_TIMEOUT);
  - character constants "$", ",", "*";
  - hex-nibble-to-value and is_hex functions.
- One sub-module, nmea_field_buffer: shift register plus length counter, with clear, push and overflow-flag ports. It is reused later by the RMC/GGA decoders.

Test Plan:
- Sentence "$GPZDA,201530.00,04,07,2002,00,00*60" must produce:
  - 6 field_valid strobes, with field 0 = "201530.00" (len 9) and field 3 = "2002" (len 4);
  - then sentence_done=1, sentence_ok=1, field_count=6, error_code=0.
- The same sentence with checksum "*61" → fields are emitted, then sentence_ok=0 and error_code=1. A lowercase "*6a" variant → error_code=1, with no error 4.
- "$GPRMC,..." interleaved with a valid ZDA sentence → no strobes for RMC and a normal result for ZDA. Empty fields ",," → field_len=0.
- An 11-character field → error_code=2. Nine fields with MAX_FIELDS=8 → error_code=3. "*6G" → error_code=4.
- "$GPZDA,2015" followed by "$GPZDA,..." valid:
  - first sentence: sentence_done with error_code=5;
  - second sentence: parsed OK, and the restart costs no lost bytes.
- With TIMEOUT=16, stop after "$GPZDA,20" → sentence_done with error_code=6 at the 16th idle clock. Asserting reset mid-field → all outputs 0 with no strobe.
